// File: rtl/u_core_ctrl_pkg.sv
// u_core_ctrl_pkg: shared state encoding and constants for the core run-state controller.
package u_core_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, BOOT, RUN, DRAIN, SLEEP, HALT} core_state_e;
    localparam int EXC_ILLEGAL_INST = 0;
    localparam int EXC_UNALIGN_PC = 1;
    localparam int PC_INC = 4;
endpackage

// File: rtl/u_core_ctrl_exc_prio.sv
// u_core_ctrl_exc_prio: masked lowest-index one-hot priority encoder.
module u_core_ctrl_exc_prio
    import u_core_ctrl_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] grant
);
    logic [N-1:0] m;
    always_comb begin
        m = req & mask;
        grant = m & (~m + N'(1));
    end
endmodule

// File: rtl/u_core_ctrl.sv
// u_core_ctrl: core run-state controller sequencing boot, run, WFI sleep and exception halt.
module u_core_ctrl
    import u_core_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int EXCEPTION_NUM = 2,
    parameter int DRAIN_CYCLES = 3
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_pulse,
    input  logic [PC_WIDTH-1:0]      start_pc,
    input  logic [EXCEPTION_NUM-1:0] core_configuration,
    input  logic                     id_vld,
    input  logic [PC_WIDTH-1:0]      id_pc,
    input  logic                     id_wfi,
    input  logic [EXCEPTION_NUM-1:0] exc_req,
    input  logic                     wake,
    output logic                     fetch_en,
    output logic                     pc_load,
    output logic [PC_WIDTH-1:0]      pc_load_val,
    output logic                     id_flush,
    output logic                     id_kill,
    output logic                     exc_vld,
    output logic [EXCEPTION_NUM-1:0] exc_cause,
    output logic [PC_WIDTH-1:0]      exc_pc,
    output logic                     core_busy,
    output logic                     core_sleep,
    output logic                     core_halted
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    core_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EXCEPTION_NUM-1:0] cfg_q, cfg_d, cause_q, cause_d, grant;
    logic [PC_WIDTH-1:0] tgt_q, tgt_d, epc_q, epc_d;
    logic by_exc_q, by_exc_d, wake_q, wake_d, rsm_q, rsm_d;
    logic start, exc_take, wfi_ev, drain_first;

    u_core_ctrl_exc_prio #(.N(EXCEPTION_NUM)) u_prio (
        .req  (exc_req),
        .mask (cfg_q),
        .grant(grant)
    );

    assign start       = start_pulse & (state_q == IDLE | state_q == HALT);
    assign exc_take    = state_q == RUN & id_vld & |grant;
    assign wfi_ev      = state_q == RUN & id_vld & id_wfi & ~|exc_req;
    assign drain_first = state_q == DRAIN & cnt_q == CW'(DRAIN_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT: state_d = start_pulse ? BOOT : state_q;
            BOOT:       state_d = RUN;
            RUN:        state_d = (exc_take | wfi_ev) ? DRAIN : RUN;
            // a wake seen at any point of a WFI drain skips SLEEP entirely
            DRAIN:      state_d = cnt_q != '0 ? DRAIN : by_exc_q ? HALT : (wake_q | wake) ? BOOT : SLEEP;
            SLEEP:      state_d = wake ? BOOT : SLEEP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_d    = start ? core_configuration : cfg_q;
        tgt_d    = start ? start_pc : wfi_ev ? id_pc + PC_WIDTH'(PC_INC) : tgt_q;
        rsm_d    = start ? 1'b0 : wfi_ev ? 1'b1 : rsm_q;
        by_exc_d = exc_take ? 1'b1 : (wfi_ev | start) ? 1'b0 : by_exc_q;
        cause_d  = start ? '0 : exc_take ? grant : cause_q;
        epc_d    = start ? '0 : exc_take ? id_pc : epc_q;
        cnt_d    = (exc_take | wfi_ev) ? CW'(DRAIN_CYCLES - 1) : (state_q == DRAIN & cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        wake_d   = state_q == DRAIN & (wake_q | wake);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q    <= '0;
            tgt_q    <= '0;
            rsm_q    <= 1'b0;
            by_exc_q <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
            cnt_q    <= '0;
            wake_q   <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            tgt_q    <= tgt_d;
            rsm_q    <= rsm_d;
            by_exc_q <= by_exc_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            cnt_q    <= cnt_d;
            wake_q   <= wake_d;
        end
    end

    // BOOT serves both the initial start (with flush) and the post-sleep resume load
    always_comb begin
        fetch_en    = state_q == RUN;
        pc_load     = state_q == BOOT;
        pc_load_val = state_q == BOOT ? tgt_q : '0;
        id_flush    = (state_q == BOOT & ~rsm_q) | drain_first;
        id_kill     = state_q == RUN & id_vld & (|exc_req | id_wfi);
        exc_vld     = drain_first & by_exc_q;
        exc_cause   = cause_q;
        exc_pc      = epc_q;
        core_busy   = state_q == BOOT | state_q == RUN | state_q == DRAIN;
        core_sleep  = state_q == SLEEP;
        core_halted = state_q == HALT;
    end
endmodule
